// File: rtl/digest_uart_tx.sv
// Serialises a captured SHA-256 digest onto the UART transmit interface.
// Define DIGEST_HEX_ASCII_EN to send lowercase hex text terminated by CR LF.
module digest_uart_tx #(
  parameter int DIGEST_BITS = 256,
  parameter int START_WAIT  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   digest_valid,
  input  logic [DIGEST_BITS-1:0] digest,
  output logic                   busy,
  output logic                   done,
  output logic                   transmit,
  output logic [7:0]             tx_byte,
  input  logic                   is_transmitting
);

  localparam int NBYTES = DIGEST_BITS / 8;
`ifdef DIGEST_HEX_ASCII_EN
  localparam int OUT_LEN = 2 * NBYTES + 2;
`else
  localparam int OUT_LEN = NBYTES;
`endif
  localparam int CW = $clog2(OUT_LEN + 1);
  localparam int WW = (START_WAIT > 1) ? $clog2(START_WAIT) : 1;

  localparam logic [CW-1:0] LAST      = CW'(OUT_LEN);
  localparam logic [WW-1:0] WAIT_LAST = WW'(START_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_DONE,
    FINISH
  } state_t;

  state_t                 state, state_n;
  logic [DIGEST_BITS-1:0] sreg, sreg_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [WW-1:0]          wcnt, wcnt_n;
  logic                   transmit_n;
  logic [7:0]             tx_byte_n;
  logic [7:0]             cur_char;

`ifdef DIGEST_HEX_ASCII_EN
  logic       nib, nib_n;
  logic [3:0] nibble;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Characters past the digest text are the CR LF terminator.
  always_comb begin
    nibble = nib ? sreg[DIGEST_BITS-5 -: 4] : sreg[DIGEST_BITS-1 -: 4];
    if (cnt == CW'(2 * NBYTES))
      cur_char = 8'h0D;
    else if (cnt > CW'(2 * NBYTES))
      cur_char = 8'h0A;
    else
      cur_char = hex_char(nibble);
  end
`else
  assign cur_char = sreg[DIGEST_BITS-1 -: 8];
`endif

  always_comb begin
    state_n    = state;
    sreg_n     = sreg;
    cnt_n      = cnt;
    wcnt_n     = wcnt;
    transmit_n = 1'b0;
    tx_byte_n  = tx_byte;
`ifdef DIGEST_HEX_ASCII_EN
    nib_n      = nib;
`endif
    unique case (state)
      IDLE: begin
        if (digest_valid) begin
          sreg_n  = digest;
          cnt_n   = '0;
          wcnt_n  = '0;
`ifdef DIGEST_HEX_ASCII_EN
          nib_n   = 1'b0;
`endif
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (!is_transmitting) begin
          tx_byte_n  = cur_char;
          transmit_n = 1'b1;
          wcnt_n     = '0;
          state_n    = WAIT_START;
        end
      end
      WAIT_START: begin
        // Fallback covers a UART whose busy edge is too short to see.
        if (is_transmitting || wcnt == WAIT_LAST)
          state_n = WAIT_DONE;
        else
          wcnt_n = wcnt + 1'b1;
      end
      WAIT_DONE: begin
        if (!is_transmitting) begin
          cnt_n = cnt + 1'b1;
`ifdef DIGEST_HEX_ASCII_EN
          nib_n = ~nib;
          if (nib)
            sreg_n = sreg << 8;
`else
          sreg_n = sreg << 8;
`endif
          state_n = (cnt_n == LAST) ? FINISH : LOAD;
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      wcnt     <= '0;
      transmit <= 1'b0;
      tx_byte  <= 8'h00;
`ifdef DIGEST_HEX_ASCII_EN
      nib      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      sreg     <= sreg_n;
      cnt      <= cnt_n;
      wcnt     <= wcnt_n;
      transmit <= transmit_n;
      tx_byte  <= tx_byte_n;
`ifdef DIGEST_HEX_ASCII_EN
      nib      <= nib_n;
`endif
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

endmodule

// File: tb/tb_digest_uart_tx.sv
// Randomised bench for digest_uart_tx with a queue-based character model.
// Honors DIGEST_HEX_ASCII_EN to match the build of the design.
module tb_digest_uart_tx;

  localparam int DB = 256;
  localparam int NB = DB / 8;
`ifdef DIGEST_HEX_ASCII_EN
  localparam int OLEN = 2 * NB + 2;
`else
  localparam int OLEN = NB;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          digest_valid = 1'b0;
  logic [DB-1:0] digest = '0;
  logic          busy;
  logic          done;
  logic          transmit;
  logic [7:0]    tx_byte;
  logic          is_transmitting = 1'b0;

  int checks = 0;
  int failures = 0;

  digest_uart_tx #(
    .DIGEST_BITS(DB),
    .START_WAIT (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .digest_valid   (digest_valid),
    .digest         (digest),
    .busy           (busy),
    .done           (done),
    .transmit       (transmit),
    .tx_byte        (tx_byte),
    .is_transmitting(is_transmitting)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  bit         exp_busy = 0;
  int         uart_mode = 0;
  bit         hold_hi = 0;
  int         cyc = 0;
  int         tx_seen = 0;
  int         done_seen = 0;
  bit         prev_done = 0;
  bit         prev_tx = 0;
  int         last_tx_cyc = -1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event missing expected event", name);
  endtask

  function automatic void push_expected(input logic [DB-1:0] d);
    string      hx;
    logic [7:0] b;
    hx = "0123456789abcdef";
    for (int k = 0; k < NB; k++) begin
      b = d[DB-1-8*k -: 8];
`ifdef DIGEST_HEX_ASCII_EN
      exp_q.push_back(hx[int'(b[7:4])]);
      exp_q.push_back(hx[int'(b[3:0])]);
`else
      exp_q.push_back(b);
`endif
    end
`ifdef DIGEST_HEX_ASCII_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endfunction

  // UART model: status rises one cycle after a request, frame lasts 10 cycles
  initial begin
    bit pend;
    int rem;
    pend = 0;
    rem = 0;
    forever begin
      @(posedge clk);
      #2;
      if (pend) begin
        pend = 0;
        rem = 10;
      end
      if (rem > 0) begin
        is_transmitting = 1'b1;
        rem--;
      end else begin
        is_transmitting = 1'b0;
      end
      if (transmit && uart_mode == 0)
        pend = 1;
      if (hold_hi)
        is_transmitting = 1'b1;
    end
  end

  // Compare process
  initial begin
    logic          s_rst, s_dv, s_itx;
    logic [DB-1:0] s_d;
    forever begin
      @(posedge clk);
      s_rst = rst_n;
      s_dv  = digest_valid;
      s_d   = digest;
      s_itx = is_transmitting;
      cyc++;
      #1;
      if (!s_rst) begin
        exp_busy = 0;
        exp_q.delete();
        last_tx_cyc = -1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_transmit", 64'(transmit), 64'd0);
        check("rst_tx_byte", 64'(tx_byte), 64'd0);
        check("rst_done", 64'(done), 64'd0);
      end else begin
        if (!exp_busy && s_dv) begin
          exp_busy = 1;
          exp_q.delete();
          push_expected(s_d);
          got.delete();
          last_tx_cyc = -1;
        end else if (prev_done) begin
          exp_busy = 0;
        end
        check("busy", 64'(busy), 64'(exp_busy));
        if (transmit) begin
          check("tx_while_uart_busy", 64'(s_itx), 64'd0);
          check("tx_single_cycle", 64'(prev_tx), 64'd0);
          if (exp_q.size() == 0)
            fail("tx_unexpected");
          else
            check("tx_byte", 64'(tx_byte), 64'(exp_q.pop_front()));
          if (last_tx_cyc >= 0)
            check("tx_spacing", 64'(cyc - last_tx_cyc),
                  (uart_mode != 0) ? 64'd6 : 64'd13);
          last_tx_cyc = cyc;
          got.push_back(tx_byte);
          tx_seen++;
        end
        if (done) begin
          check("done_chars_left", 64'(exp_q.size()), 64'd0);
          check("done_delay", 64'(cyc - last_tx_cyc),
                (uart_mode != 0) ? 64'd5 : 64'd12);
          done_seen++;
        end
      end
      prev_done = done;
      prev_tx = transmit;
    end
  end

  function automatic logic [DB-1:0] rand_digest();
    logic [DB-1:0] d;
    d = '0;
    for (int i = 0; i < DB / 32; i++)
      d = {d[DB-33:0], 32'($urandom())};
    return d;
  endfunction

  task automatic send_digest(input logic [DB-1:0] d);
    @(negedge clk);
    digest_valid = 1'b1;
    digest = d;
    @(negedge clk);
    digest_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    int d0;
    n = 0;
    d0 = done_seen;
    while (done_seen == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_seen == d0)
      fail(name);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_tx(input string name, input int count, input int budget);
    int n;
    int target;
    n = 0;
    target = tx_seen + count;
    while (tx_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx_seen < target)
      fail(name);
  endtask

  initial begin
    logic [DB-1:0] d;
    logic [DB-1:0] d2;
    int            n;
    int            dones;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Incrementing digest, latency and ordering
    d = '0;
    for (int k = 0; k < NB; k++)
      d = {d[DB-9:0], 8'(k)};
    @(negedge clk);
    digest_valid = 1'b1;
    digest = d;
    @(posedge clk);
    #2;
    check("t1_busy_after_capture", 64'(busy), 64'd1);
    check("t1_no_tx_in_load", 64'(transmit), 64'd0);
    @(negedge clk);
    digest_valid = 1'b0;
    @(posedge clk);
    #2;
    check("t1_first_tx", 64'(transmit), 64'd1);
`ifdef DIGEST_HEX_ASCII_EN
    check("t1_first_char", 64'(tx_byte), 64'h30);
`else
    check("t1_first_byte", 64'(tx_byte), 64'h00);
`endif
    wait_done("t1_done_timeout", 4000);
    check("t1_len", 64'(got.size()), 64'(OLEN));
`ifndef DIGEST_HEX_ASCII_EN
    check("t1_last_byte", 64'(got[NB-1]), 64'h1F);
`endif
    dones = 1;

`ifdef DIGEST_HEX_ASCII_EN
    // SHA-256("abc") as hex text
    d = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    send_digest(d);
    wait_done("t2_done_timeout", 4000);
    check("t2_len", 64'(got.size()), 64'd66);
    check("t2_char0", 64'(got[0]), 64'h62);
    check("t2_char1", 64'(got[1]), 64'h61);
    check("t2_cr", 64'(got[64]), 64'h0D);
    check("t2_lf", 64'(got[65]), 64'h0A);
    dones++;
`endif

    // UART status held high at capture
    hold_hi = 1;
    repeat (2) @(negedge clk);
    send_digest(rand_digest());
    repeat (20) begin
      @(negedge clk);
      check("t3_hold_no_tx", 64'(transmit), 64'd0);
    end
    hold_hi = 0;
    n = 0;
    @(posedge clk);
    while (is_transmitting && n < 10) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("t3_tx_after_release", 64'(transmit), 64'd1);
    wait_done("t3_done_timeout", 4000);
    check("t3_len", 64'(got.size()), 64'(OLEN));
    dones++;

    // UART never reports busy
    uart_mode = 1;
    send_digest(rand_digest());
    wait_done("t4_done_timeout", 4000);
    check("t4_len", 64'(got.size()), 64'(OLEN));
    uart_mode = 0;
    dones++;

    // Second strobe mid-message is ignored
    d = rand_digest();
    d2 = ~d;
    send_digest(d);
    wait_tx("t5_tx_timeout", 5, 400);
    send_digest(d2);
    wait_done("t5_done_timeout", 4000);
    check("t5_len", 64'(got.size()), 64'(OLEN));
    repeat (30) @(negedge clk);
    dones++;
    check("t5_single_done", 64'(done_seen), 64'(dones));

    // Reset mid-message, then a clean restart
    send_digest(rand_digest());
    wait_tx("t6_tx_timeout", 10, 600);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t6_idle_after_rst", 64'(transmit), 64'd0);
    end
    d = rand_digest();
    send_digest(d);
    wait_done("t6_done_timeout", 4000);
    check("t6_len", 64'(got.size()), 64'(OLEN));
`ifndef DIGEST_HEX_ASCII_EN
    check("t6_restart_byte0", 64'(got[0]), 64'(d[DB-1 -: 8]));
`endif
    dones++;

    // Random digests, random UART behaviour
    for (int i = 0; i < 4; i++) begin
      uart_mode = int'($urandom_range(0, 1));
      send_digest(rand_digest());
      wait_done("t7_done_timeout", 4000);
      check("t7_len", 64'(got.size()), 64'(OLEN));
      dones++;
    end
    uart_mode = 0;

    check("done_total", 64'(done_seen), 64'(dones));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
